lc3b_reg_scoreboard: RTL and testbench
======================================

Name: lc3b_reg_scoreboard

Overview:
- Tracks in-flight register and condition-code writes for the LC-3b pipeline and generates the decode-stage dependency stall.
- The decode stage marks a destination pending when an instruction issues. Writeback clears the mark on retire. The squash path clears it for a killed instruction.
- Replaces per-stage drid/ld_reg comparison with per-register pending counters, so pipeline depth can grow without new comparators.

Parameters:
- CNT_W, 2, width of each pending-write counter; max in-flight writes per target = 2^CNT_W - 1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode instruction advances into EX this cycle.
- issue_ld_reg  in  1  issuing instruction writes a register.
- issue_drid  in  3  issuing destination register (lc3b_reg).
- issue_ld_cc  in  1  issuing instruction writes CC.
- wb_valid  in  1  instruction retires in WB this cycle.
- wb_ld_reg  in  1  retiring instruction writes a register.
- wb_drid  in  3  retiring destination register.
- wb_ld_cc  in  1  retiring instruction writes CC.
- kill_valid  in  1  an issued, unretired instruction is squashed this cycle.
- kill_ld_reg  in  1  squashed instruction had a register write.
- kill_drid  in  3  squashed destination register.
- kill_ld_cc  in  1  squashed instruction had a CC write.
- sr1, sr2  in  3 each  decode source registers.
- sr1_needed, sr2_needed  in  1 each  source is actually read.
- dec_valid  in  1  decode holds a valid instruction.
- dec_opcode  in  4  decode opcode (lc3b_opcode).
- dep_stall  out  1  combinational stall to decode.
- busy_vec  out  8  registered; bit i = counter[i] != 0.
- cc_busy  out  1  registered; CC counter != 0.
- sb_error  out  1  sticky protocol-error flag.

Behaviour:
- State: eight register counters cnt[0..7], one CC counter cnt_cc, all CNT_W bits wide, plus sb_error.
- Reset (reset_n low, asynchronous): all counters = 0, sb_error = 0. As a result, busy_vec = 0, cc_busy = 0 and dep_stall = 0. Reset mid-operation discards all pending state immediately.
- Per-cycle update for each register i: next = cnt + inc - dec_wb - dec_kill.
  - inc = issue_valid & issue_ld_reg & (issue_drid == i).
  - dec_wb = wb_valid & wb_ld_reg & (wb_drid == i).
  - dec_kill = kill_valid & kill_ld_reg & (kill_drid == i).
- cnt_cc uses the same update rule with the ld_cc terms.
- All three events on the same target in one cycle are legal. The net delta ranges from -2 to +1.
- Overflow: if the computed next value exceeds 2^CNT_W - 1, hold at max and set sb_error.
- Underflow: if the computed next value is below 0, hold at 0 and set sb_error.
- sb_error clears only on reset.
- dep_stall = dec_valid & (any of the following):
  - sr1_needed & cnt[sr1] != 0.
  - sr2_needed & cnt[sr2] != 0.
  - dec_opcode == op_br & cnt_cc != 0.
- dep_stall is purely combinational from the current registered counters and the decode inputs.
- Issue in the same cycle does not affect that cycle's dep_stall. The caller must not assert issue_valid while dep_stall = 1; the block does not check this.
- busy_vec and cc_busy are derived from registered counters (zero latency from counter state, one cycle after the update event).

Optional Feature:
- SCOREBOARD_BYPASS_EN defined: a source whose counter equals 1 and that is retiring this cycle (dec_wb term for that register = 1, with no same-cycle issue to it) does not stall. The same rule applies to CC for op_br. This relies on register-file write-through.
- Not defined: stall uses counter state only, so an instruction retiring in WB still stalls decode for that cycle.

Test Plan:
- Reset, then dec_valid=1, sr1=R3, sr1_needed=1 -> dep_stall=0, busy_vec=8'h00, sb_error=0.
- Issue ADD with drid=R3 in cycle 0; in cycles 1-3 decode needs sr1=R3 -> dep_stall=1. Retire R3 in cycle 3 -> busy_vec[3]=0 and dep_stall=0 from cycle 4. With SCOREBOARD_BYPASS_EN, dep_stall=0 already in cycle 3.
- Issue two writes to R5 back-to-back -> cnt[5]=2. Retire one -> busy_vec[5] still 1. Retire the second -> busy_vec[5]=0.
- In one cycle, issue R2, retire R2 and kill R2 with cnt[2]=2 -> cnt[2]=1, sb_error=0.
- Issue a CC-setting instruction, then decode op_br with sr needs=0 -> dep_stall=1 until the CC retire. Kill the CC instead of retiring -> cc_busy=0 next cycle.
- Retire R1 with cnt[1]=0 -> sb_error=1 and cnt[1] stays 0. Issue R1 four times with CNT_W=2 -> saturates at 3. Assert reset_n low mid-sequence -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lc3b_reg_scoreboard.sv
// Register/CC pending-write scoreboard for the LC-3b pipeline, generating the decode dependency stall.
// Define SCOREBOARD_BYPASS_EN to let a source retiring this cycle (count 1, no same-cycle issue) skip the stall.
module lc3b_reg_scoreboard #(
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       issue_valid,
   input  logic       issue_ld_reg,
   input  logic [2:0] issue_drid,
   input  logic       issue_ld_cc,
   input  logic       wb_valid,
   input  logic       wb_ld_reg,
   input  logic [2:0] wb_drid,
   input  logic       wb_ld_cc,
   input  logic       kill_valid,
   input  logic       kill_ld_reg,
   input  logic [2:0] kill_drid,
   input  logic       kill_ld_cc,
   input  logic [2:0] sr1,
   input  logic [2:0] sr2,
   input  logic       sr1_needed,
   input  logic       sr2_needed,
   input  logic       dec_valid,
   input  logic [3:0] dec_opcode,
   output logic       dep_stall,
   output logic [7:0] busy_vec,
   output logic       cc_busy,
   output logic       sb_error
);

   localparam logic [3:0] OP_BR = 4'b0000;
   localparam int SUM_W = CNT_W + 2;
   localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef struct packed {
      cnt_t cnt;
      logic err;
   } upd_t;

   cnt_t cnt_q [8];
   cnt_t cnt_d [8];
   cnt_t cnt_cc_q, cnt_cc_d;
   logic sb_error_q, sb_error_d;

   logic [7:0] inc_reg, wb_reg, kill_reg, bypass_reg, stall_reg;
   logic       inc_cc, wb_cc, kill_cc, bypass_cc, stall_cc;

   // Widened signed sum so a net delta of -2..+1 can be seen past either rail before clamping.
   function automatic upd_t next_cnt(input cnt_t cur, input logic inc, input logic dec_a,
                                     input logic dec_b);
      logic signed [SUM_W-1:0] sum;
      upd_t r;
      sum = $signed(SUM_W'(cur)) + $signed(SUM_W'(inc))
          - $signed(SUM_W'(dec_a)) - $signed(SUM_W'(dec_b));
      if (sum > CNT_MAX) begin
         r.cnt = '1;
         r.err = 1'b1;
      end else if (sum < 0) begin
         r.cnt = '0;
         r.err = 1'b1;
      end else begin
         r.cnt = sum[CNT_W-1:0];
         r.err = 1'b0;
      end
      return r;
   endfunction

   // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      upd_t u;
      sb_error_d = sb_error_q;
      for (int i = 0; i < 8; i++) begin
         inc_reg[i]  = issue_valid & issue_ld_reg & (issue_drid == 3'(i));
         wb_reg[i]   = wb_valid & wb_ld_reg & (wb_drid == 3'(i));
         kill_reg[i] = kill_valid & kill_ld_reg & (kill_drid == 3'(i));
         u           = next_cnt(cnt_q[i], inc_reg[i], wb_reg[i], kill_reg[i]);
         cnt_d[i]    = u.cnt;
         sb_error_d  = sb_error_d | u.err;
      end
      inc_cc     = issue_valid & issue_ld_cc;
      wb_cc      = wb_valid & wb_ld_cc;
      kill_cc    = kill_valid & kill_ld_cc;
      u          = next_cnt(cnt_cc_q, inc_cc, wb_cc, kill_cc);
      cnt_cc_d   = u.cnt;
      sb_error_d = sb_error_d | u.err;
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
`ifdef SCOREBOARD_BYPASS_EN
         bypass_reg[i] = (cnt_q[i] == cnt_t'(1)) & wb_reg[i] & ~inc_reg[i];
`else
         bypass_reg[i] = 1'b0;
`endif
         stall_reg[i] = (cnt_q[i] != '0) & ~bypass_reg[i];
      end
`ifdef SCOREBOARD_BYPASS_EN
      bypass_cc = (cnt_cc_q == cnt_t'(1)) & wb_cc & ~inc_cc;
`else
      bypass_cc = 1'b0;
`endif
      stall_cc  = (cnt_cc_q != '0) & ~bypass_cc;
      dep_stall = dec_valid & ((sr1_needed & stall_reg[sr1]) |
                               (sr2_needed & stall_reg[sr2]) |
                               ((dec_opcode == OP_BR) & stall_cc));
   end

   // NOTE: the counters are architectural tracking state, so every entry is reset, not just a valid bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
         cnt_cc_q   <= '0;
         sb_error_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates ordered against the same old values.
         for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
         cnt_cc_q   <= cnt_cc_d;
         sb_error_q <= sb_error_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) busy_vec[i] = (cnt_q[i] != '0);
   end
   assign cc_busy  = (cnt_cc_q != '0);
   assign sb_error = sb_error_q;

endmodule

// File: tb/tb_lc3b_reg_scoreboard.sv
// Directed self-checking bench for lc3b_reg_scoreboard; expectations follow SCOREBOARD_BYPASS_EN if defined.
module tb_lc3b_reg_scoreboard;

   logic       clk, reset_n;
   logic       issue_valid, issue_ld_reg, issue_ld_cc;
   logic [2:0] issue_drid;
   logic       wb_valid, wb_ld_reg, wb_ld_cc;
   logic [2:0] wb_drid;
   logic       kill_valid, kill_ld_reg, kill_ld_cc;
   logic [2:0] kill_drid;
   logic [2:0] sr1, sr2;
   logic       sr1_needed, sr2_needed, dec_valid;
   logic [3:0] dec_opcode;
   logic       dep_stall, cc_busy, sb_error;
   logic [7:0] busy_vec;

   int tests_run = 0;
   int tests_failed = 0;

`ifdef SCOREBOARD_BYPASS_EN
   localparam logic STALL_ON_RETIRE = 1'b0;
`else
   localparam logic STALL_ON_RETIRE = 1'b1;
`endif

   lc3b_reg_scoreboard #(.CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .issue_valid(issue_valid), .issue_ld_reg(issue_ld_reg), .issue_drid(issue_drid),
      .issue_ld_cc(issue_ld_cc),
      .wb_valid(wb_valid), .wb_ld_reg(wb_ld_reg), .wb_drid(wb_drid), .wb_ld_cc(wb_ld_cc),
      .kill_valid(kill_valid), .kill_ld_reg(kill_ld_reg), .kill_drid(kill_drid),
      .kill_ld_cc(kill_ld_cc),
      .sr1(sr1), .sr2(sr2), .sr1_needed(sr1_needed), .sr2_needed(sr2_needed),
      .dec_valid(dec_valid), .dec_opcode(dec_opcode),
      .dep_stall(dep_stall), .busy_vec(busy_vec), .cc_busy(cc_busy), .sb_error(sb_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle();
      issue_valid = 0; issue_ld_reg = 0; issue_drid = 0; issue_ld_cc = 0;
      wb_valid = 0; wb_ld_reg = 0; wb_drid = 0; wb_ld_cc = 0;
      kill_valid = 0; kill_ld_reg = 0; kill_drid = 0; kill_ld_cc = 0;
      sr1 = 0; sr2 = 0; sr1_needed = 0; sr2_needed = 0; dec_valid = 0; dec_opcode = 4'b0001;
   endtask

   // Advance one clock and settle just after the active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      dec_valid = 1; sr1 = 3; sr1_needed = 1;
      #1;
      tests_run++;
      if (dep_stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b exp 0", dep_stall); end
      tests_run++;
      if (busy_vec !== 8'h00) begin tests_failed++; $display("FAIL reset_busy: got %h exp 00", busy_vec); end
      tests_run++;
      if (sb_error !== 1'b0 || cc_busy !== 1'b0) begin
         tests_failed++; $display("FAIL reset_flags: sb_error=%b cc_busy=%b exp 0 0", sb_error, cc_busy);
      end
   endtask

   task automatic test_raw_stall();
      idle();
      dec_valid = 1; sr1 = 3; sr1_needed = 1;
      issue_valid = 1; issue_ld_reg = 1; issue_drid = 3;
      #1;
      tests_run++;
      if (dep_stall !== 1'b0) begin tests_failed++; $display("FAIL raw_issue_cycle: got %b exp 0", dep_stall); end
      tick();
      issue_valid = 0;
      for (int c = 1; c <= 2; c++) begin
         #1;
         tests_run++;
         if (dep_stall !== 1'b1 || busy_vec !== 8'h08) begin
            tests_failed++;
            $display("FAIL raw_cycle%0d: stall=%b busy=%h exp 1 08", c, dep_stall, busy_vec);
         end
         tick();
      end
      wb_valid = 1; wb_ld_reg = 1; wb_drid = 3;
      #1;
      tests_run++;
      if (dep_stall !== STALL_ON_RETIRE) begin
         tests_failed++; $display("FAIL raw_retire_cycle: got %b exp %b", dep_stall, STALL_ON_RETIRE);
      end
      tick();
      wb_valid = 0;
      #1;
      tests_run++;
      if (dep_stall !== 1'b0 || busy_vec !== 8'h00) begin
         tests_failed++; $display("FAIL raw_after_retire: stall=%b busy=%h exp 0 00", dep_stall, busy_vec);
      end
   endtask

   task automatic test_back_to_back();
      idle();
      issue_valid = 1; issue_ld_reg = 1; issue_drid = 5;
      tick();
      tick();
      idle();
      tests_run++;
      if (busy_vec !== 8'h20) begin tests_failed++; $display("FAIL b2b_two: busy=%h exp 20", busy_vec); end
      wb_valid = 1; wb_ld_reg = 1; wb_drid = 5;
      tick();
      tests_run++;
      if (busy_vec !== 8'h20) begin tests_failed++; $display("FAIL b2b_one_left: busy=%h exp 20", busy_vec); end
      tick();
      idle();
      tests_run++;
      if (busy_vec !== 8'h00 || sb_error !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_drained: busy=%h err=%b exp 00 0", busy_vec, sb_error);
      end
   endtask

   task automatic test_triple_event();
      idle();
      issue_valid = 1; issue_ld_reg = 1; issue_drid = 2;
      tick();
      tick();
      wb_valid = 1; wb_ld_reg = 1; wb_drid = 2;
      kill_valid = 1; kill_ld_reg = 1; kill_drid = 2;
      tick();
      idle();
      tests_run++;
      if (busy_vec !== 8'h04 || sb_error !== 1'b0) begin
         tests_failed++; $display("FAIL triple_net: busy=%h err=%b exp 04 0", busy_vec, sb_error);
      end
      wb_valid = 1; wb_ld_reg = 1; wb_drid = 2;
      tick();
      idle();
      tests_run++;
      if (busy_vec !== 8'h00 || sb_error !== 1'b0) begin
         tests_failed++; $display("FAIL triple_drain: busy=%h err=%b exp 00 0", busy_vec, sb_error);
      end
   endtask

   task automatic test_cc();
      idle();
      issue_valid = 1; issue_ld_cc = 1;
      tick();
      idle();
      dec_valid = 1; dec_opcode = 4'b0000;
      #1;
      tests_run++;
      if (cc_busy !== 1'b1 || dep_stall !== 1'b1) begin
         tests_failed++; $display("FAIL cc_br_stall: cc_busy=%b stall=%b exp 1 1", cc_busy, dep_stall);
      end
      dec_opcode = 4'b0001;
      #1;
      tests_run++;
      if (dep_stall !== 1'b0) begin tests_failed++; $display("FAIL cc_non_br: stall=%b exp 0", dep_stall); end
      dec_opcode = 4'b0000;
      wb_valid = 1; wb_ld_cc = 1;
      #1;
      tests_run++;
      if (dep_stall !== STALL_ON_RETIRE) begin
         tests_failed++; $display("FAIL cc_retire_cycle: stall=%b exp %b", dep_stall, STALL_ON_RETIRE);
      end
      tick();
      wb_valid = 0; wb_ld_cc = 0;
      #1;
      tests_run++;
      if (dep_stall !== 1'b0 || cc_busy !== 1'b0) begin
         tests_failed++; $display("FAIL cc_retired: stall=%b cc_busy=%b exp 0 0", dep_stall, cc_busy);
      end
      issue_valid = 1; issue_ld_cc = 1;
      tick();
      issue_valid = 0; issue_ld_cc = 0;
      tests_run++;
      if (cc_busy !== 1'b1) begin tests_failed++; $display("FAIL cc_reissue: cc_busy=%b exp 1", cc_busy); end
      kill_valid = 1; kill_ld_cc = 1;
      tick();
      idle();
      tests_run++;
      if (cc_busy !== 1'b0 || sb_error !== 1'b0) begin
         tests_failed++; $display("FAIL cc_killed: cc_busy=%b err=%b exp 0 0", cc_busy, sb_error);
      end
   endtask

   task automatic test_saturate();
      idle();
      issue_valid = 1; issue_ld_reg = 1; issue_drid = 1;
      repeat (3) tick();
      tests_run++;
      if (sb_error !== 1'b0 || busy_vec !== 8'h02) begin
         tests_failed++; $display("FAIL sat_at_max: err=%b busy=%h exp 0 02", sb_error, busy_vec);
      end
      tick();
      idle();
      tests_run++;
      if (sb_error !== 1'b1) begin tests_failed++; $display("FAIL sat_overflow_err: err=%b exp 1", sb_error); end
      wb_valid = 1; wb_ld_reg = 1; wb_drid = 1;
      repeat (2) tick();
      tests_run++;
      if (busy_vec !== 8'h02) begin tests_failed++; $display("FAIL sat_held_max: busy=%h exp 02", busy_vec); end
      tick();
      idle();
      tests_run++;
      if (busy_vec !== 8'h00 || sb_error !== 1'b1) begin
         tests_failed++; $display("FAIL sat_drained: busy=%h err=%b exp 00 1", busy_vec, sb_error);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      tests_run++;
      if (sb_error !== 1'b0) begin tests_failed++; $display("FAIL uf_cleared: err=%b exp 0", sb_error); end
      wb_valid = 1; wb_ld_reg = 1; wb_drid = 1;
      tick();
      idle();
      tests_run++;
      if (sb_error !== 1'b1 || busy_vec !== 8'h00) begin
         tests_failed++; $display("FAIL uf_err: err=%b busy=%h exp 1 00", sb_error, busy_vec);
      end
      issue_valid = 1; issue_ld_reg = 1; issue_drid = 1;
      tick();
      idle();
      tests_run++;
      if (busy_vec !== 8'h02) begin tests_failed++; $display("FAIL uf_held_zero: busy=%h exp 02", busy_vec); end
      wb_valid = 1; wb_ld_reg = 1; wb_drid = 1;
      tick();
      idle();
      tests_run++;
      if (busy_vec !== 8'h00 || sb_error !== 1'b1) begin
         tests_failed++; $display("FAIL uf_sticky: busy=%h err=%b exp 00 1", busy_vec, sb_error);
      end
   endtask

   task automatic test_async_reset();
      idle();
      issue_valid = 1; issue_ld_reg = 1; issue_drid = 4; issue_ld_cc = 1;
      tick();
      idle();
      dec_valid = 1; sr1 = 4; sr1_needed = 1;
      #1;
      tests_run++;
      if (dep_stall !== 1'b1 || busy_vec !== 8'h10 || cc_busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL ar_before: stall=%b busy=%h cc=%b exp 1 10 1", dep_stall, busy_vec, cc_busy);
      end
      #2;
      reset_n = 0;
      #1;
      tests_run++;
      if (dep_stall !== 1'b0 || busy_vec !== 8'h00 || cc_busy !== 1'b0 || sb_error !== 1'b0) begin
         tests_failed++;
         $display("FAIL ar_cleared: stall=%b busy=%h cc=%b err=%b exp 0 00 0 0",
                  dep_stall, busy_vec, cc_busy, sb_error);
      end
      @(negedge clk);
      reset_n = 1;
      tick();
   endtask

   initial begin
      idle();
      reset_n = 0;
      test_reset();
      test_raw_stall();
      test_back_to_back();
      test_triple_event();
      test_cc();
      test_saturate();
      test_underflow();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
